// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained through a
// carry vector, with sum/carry-out and a valid flag captured on one edge.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
);
    localparam int STAGES = 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [STAGES:0]  vld_pipe;

    assign carry[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            fa_cell u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // Result registers only load on a valid cycle; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_out <= '0;
            c_out <= 1'b0;
        end else if (in_valid) begin
            s_out <= sum;
            c_out <= carry[WIDTH];
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg: WIDTH=1 and WIDTH=8 instances against an
// arithmetic reference (a + b + c_in).

module tb_full_adder_reg;
    logic       clk;
    logic       rst_n;

    logic       iv1, a1, b1, ci1;
    logic       ov1, s1, co1;

    logic       iv8, ci8;
    logic [7:0] a8, b8;
    logic       ov8, co8;
    logic [7:0] s8;

    int n_tests;
    int n_fail;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .c_in(ci1),
        .out_valid(ov1), .s_out(s1), .c_out(co1)
    );

    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .c_in(ci8),
        .out_valid(ov8), .s_out(s8), .c_out(co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0;
        #3;
        n_tests++;
        if ({ov1, co1, s1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_w1: got v/c/s=%b, want 000", {ov1, co1, s1});
        end
        n_tests++;
        if ({ov8, co8, s8} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got v=%b c=%b s=%h, want 0 0 00", ov8, co8, s8);
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_truth_table();
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            iv1 = 1'b1;
            a1  = v[2];
            b1  = v[1];
            ci1 = v[0];
            exp = 2'(a1) + 2'(b1) + 2'(ci1);
            step();
            n_tests++;
            if ({ov1, co1, s1} !== {1'b1, exp[1], exp[0]}) begin
                n_fail++;
                $display("FAIL truth_%0d: got v/c/s=%b, want %b", v, {ov1, co1, s1}, {1'b1, exp});
            end
        end
        iv1 = 1'b0;
    endtask

    task automatic test_async_reset();
        iv1 = 1; a1 = 1; b1 = 1; ci1 = 1;
        step();
        n_tests++;
        if ({ov1, co1, s1} !== 3'b111) begin
            n_fail++;
            $display("FAIL preload_111: got v/c/s=%b, want 111", {ov1, co1, s1});
        end
        iv1 = 0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ov1, co1, s1} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got v/c/s=%b, want 000", {ov1, co1, s1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++;
        if ({ov1, co1, s1} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_release_idle: got v/c/s=%b, want 000", {ov1, co1, s1});
        end
        iv1 = 1; a1 = 0; b1 = 1; ci1 = 1;
        step();
        n_tests++;
        if ({ov1, co1, s1} !== 3'b110) begin
            n_fail++;
            $display("FAIL first_after_reset: got v/c/s=%b, want 110", {ov1, co1, s1});
        end
        iv1 = 0;
    endtask

    task automatic test_hold();
        iv1 = 1; a1 = 1; b1 = 0; ci1 = 0;
        step();
        n_tests++;
        if ({ov1, co1, s1} !== 3'b101) begin
            n_fail++;
            $display("FAIL hold_load: got v/c/s=%b, want 101", {ov1, co1, s1});
        end
        iv1 = 0; a1 = 1; b1 = 1; ci1 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({ov1, co1, s1} !== 3'b001) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: got v/c/s=%b, want 001", k, {ov1, co1, s1});
            end
        end
    endtask

    task automatic test_directed_w8();
        logic [8:0] av [3];
        logic [8:0] bv [3];
        logic       cv [3];
        logic [8:0] want [3];
        av[0] = 9'h0FF; bv[0] = 9'h000; cv[0] = 1'b1; want[0] = 9'h100;
        av[1] = 9'h05A; bv[1] = 9'h03C; cv[1] = 1'b0; want[1] = 9'h096;
        av[2] = 9'h080; bv[2] = 9'h080; cv[2] = 1'b1; want[2] = 9'h101;
        for (int k = 0; k < 3; k++) begin
            iv8 = 1; a8 = av[k][7:0]; b8 = bv[k][7:0]; ci8 = cv[k];
            step();
            n_tests++;
            if ({ov8, co8, s8} !== {1'b1, want[k]}) begin
                n_fail++;
                $display("FAIL w8_directed_%0d: got v=%b c=%b s=%h, want v=1 c=%b s=%h",
                         k, ov8, co8, s8, want[k][8], want[k][7:0]);
            end
        end
        iv8 = 0;
    endtask

    task automatic test_back_to_back();
        int exp_sum;
        int errs;
        errs = 0;
        for (int k = 0; k < 1000; k++) begin
            iv8 = 1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
            exp_sum = int'(a8) + int'(b8) + int'(ci8);
            step();
            n_tests++;
            if (ov8 !== 1'b1 || {co8, s8} !== 9'(exp_sum)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b_%0d: got v=%b sum=%0d, want v=1 sum=%0d",
                             k, ov8, {co8, s8}, exp_sum);
            end
        end
        iv8 = 0;
    endtask

    task automatic test_random_valid();
        int  held;
        int  errs;
        logic v;
        errs = 0;
        held = int'({co8, s8}) ;
        // Seed the reference with a known result so held values are model-derived.
        iv8 = 1; a8 = 8'hC3; b8 = 8'h71; ci8 = 1'b0;
        held = 'hC3 + 'h71;
        step();
        for (int k = 0; k < 300; k++) begin
            v   = 1'($urandom_range(0, 1));
            iv8 = v;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
            if (v) held = int'(a8) + int'(b8) + int'(ci8);
            step();
            n_tests++;
            if (ov8 !== v || {co8, s8} !== 9'(held)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_valid_%0d: got v=%b sum=%0d, want v=%b sum=%0d",
                             k, ov8, {co8, s8}, v, held);
            end
        end
        iv8 = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_truth_table();
        test_async_reset();
        test_hold();
        test_directed_w8();
        test_back_to_back();
        test_random_valid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered ripple-carry adder built from per-bit full-adder cells.
- Adds two WIDTH-bit operands and a carry-in, and registers the sum and carry-out with a valid flag.
- With WIDTH=1 it is the single-bit full adder used as the basic arithmetic cell of the datapath.
- Wider instances serve as small adders inside the ALU.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  when high, the operands are captured this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in into bit 0.
- out_valid  output  1  high for one cycle when s_out/c_out hold a new result.
- s_out  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out of the MSB.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: s_out=0, c_out=0, out_valid=0, independent of clk. Release is synchronous to the next rising edge.
- Bit cell, for i = 0..WIDTH-1, with c[0]=c_in:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
- Result is {c_out, s_out} = a + b + c_in, WIDTH+1 bits wide. No overflow is lost: the full carry goes to c_out.
- Latency: 1 cycle. At a rising edge with in_valid=1, s_out, c_out and out_valid=1 update together.
- At a rising edge with in_valid=0:
  - s_out and c_out hold their previous values.
  - out_valid goes to 0.
- Back-to-back in_valid=1 gives one result per cycle (full throughput). There is no backpressure.
- Asserting reset mid-stream discards any in-flight result. After release, the first valid result appears one edge after in_valid is sampled high.
- Purely two-state behaviour is required. X/Z on inputs is outside the contract.
- No internal state exists beyond the output registers.

Test Plan:
- WIDTH=1, truth table, in_valid=1, one cycle per vector. (a,b,c_in) -> (s_out,c_out), checked one cycle later:
  - 000 -> 0,0
  - 001 -> 1,0
  - 010 -> 1,0
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,1
  - 110 -> 0,1
  - 111 -> 1,1
  - out_valid=1 on each result cycle.
- Reset: drive rst_n=0 between clock edges after loading a=1,b=1,c_in=1 -> s_out=0, c_out=0, out_valid=0 immediately, without waiting for a clock edge.
- Hold: load a=1,b=0,c_in=0 (s_out=1), then in_valid=0 with inputs 1,1,1 for 3 cycles -> s_out stays 1, c_out stays 0, out_valid=0.
- WIDTH=8, carry ripple: a=8'hFF, b=8'h00, c_in=1 -> s_out=8'h00, c_out=1.
- WIDTH=8, mixed: a=8'h5A, b=8'h3C, c_in=0 -> s_out=8'h96, c_out=0. Then a=8'h80, b=8'h80, c_in=1 -> s_out=8'h01, c_out=1.
- Random: WIDTH=8, 1000 back-to-back vectors -> each {c_out,s_out} equals a+b+c_in of the previous cycle.
